pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the MIPS31 CPU; the stage directly upstream of the PC+4 incrementer.
- Drives the current PC to the incrementer and to instruction memory, and takes PC+4 back from the incrementer.
- Selects the next PC: sequential, branch, jump, jr, exception vector or eret.
- Runs a req/ack fetch handshake with instruction memory and holds the fetched instruction until the core retires it.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/pc_fetch_unit_if.sv | 24 ++
 rtl/pc_fetch_unit_npc_calc.sv | 37 +++
 rtl/pc_fetch_unit.sv | 99 +++++++++
 tb/tb_pc_fetch_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS31 fetch stage: next-PC select encodings,
// default reset/exception addresses and the fetch FSM state type.
package mips_pkg;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0040_0004;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    // Force a register-sourced target onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit
// (master) and instruction memory (slave).
interface pc_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection: sequential, branch, jump or jr, plus a
// flag reporting a jr target that is not word aligned.
module npc_calc
    import mips_pkg::*;
(
    input  logic [1:0]  npc_sel_i,
    input  logic        br_taken_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] npc_o,
    output logic        misalign_o
);

    logic signed [31:0] br_off;

    // Branch offset is the sign-extended word offset scaled to bytes.
    assign br_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};

    // Select the next PC; arithmetic wraps modulo 2^32.
    always_comb begin
        npc_o      = pc_plus4_i;
        misalign_o = 1'b0;
        case (npc_sel_i)
            NPC_SEQ: npc_o = pc_plus4_i;
            NPC_BR:  npc_o = br_taken_i ? (pc_plus4_i + $unsigned(br_off)) : pc_plus4_i;
            NPC_J:   npc_o = {pc_plus4_i[31:28], instr_index_i, 2'b00};
            NPC_JR: begin
                npc_o      = word_align(rs_val_i);
                misalign_o = |rs_val_i[1:0];
            end
            default: npc_o = pc_plus4_i;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer. Requests the word at the
// current PC, holds it until the core retires it, then advances to the
// selected next PC. Exception and eret redirects override everything but reset.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [31:0]            pc_out,
    input  logic [31:0]            pc_plus4,
    input  logic [1:0]             npc_sel,
    input  logic                   br_taken,
    input  logic [15:0]            imm16,
    input  logic [25:0]            instr_index,
    input  logic [31:0]            rs_val,
    input  logic                   exc_req,
    input  logic                   eret,
    input  logic [31:0]            epc,
    input  logic                   stall,
    pc_fetch_unit_if.master        imem,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic                   misalign
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         instr_valid_q;
    logic         misalign_q;
    logic [31:0]  npc_d;
    logic         npc_misalign_d;

    npc_calc u_npc_calc (
        .npc_sel_i     (npc_sel),
        .br_taken_i    (br_taken),
        .imm16_i       (imm16),
        .instr_index_i (instr_index),
        .rs_val_i      (rs_val),
        .pc_plus4_i    (pc_plus4),
        .npc_o         (npc_d),
        .misalign_o    (npc_misalign_d)
    );

    // Fetch FSM: redirects first, then fetch/hold sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (exc_req) begin
                // Any ack arriving alongside the redirect is dropped.
                pc_q          <= EXC_VECTOR;
                instr_valid_q <= 1'b0;
                state_q       <= FETCH;
            end else if (eret) begin
                pc_q          <= word_align(epc);
                misalign_q    <= |epc[1:0];
                instr_valid_q <= 1'b0;
                state_q       <= FETCH;
            end else begin
                case (state_q)
                    FETCH: begin
                        if (imem.imem_ack) begin
                            instr_q       <= imem.imem_rdata;
                            instr_valid_q <= 1'b1;
                            state_q       <= HOLD;
                        end
                    end
                    HOLD: begin
                        // Acks while holding are ignored; only retire moves on.
                        if (!stall) begin
                            pc_q          <= npc_d;
                            misalign_q    <= npc_misalign_d;
                            instr_valid_q <= 1'b0;
                            state_q       <= FETCH;
                        end
                    end
                    default: state_q <= FETCH;
                endcase
            end
        end
    end

    assign pc_out         = pc_q;
    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: models the external PC+4 incrementer and a
// simple instruction memory, and scoreboards every fetched word.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

    logic        clk;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_val;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misalign;

    pc_fetch_unit_if bus ();

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_pc[$];
    logic [31:0] sb_ins[$];
    logic [31:0] last_instr;
    logic [31:0] e_pc;
    logic [31:0] e_ins;

    pc_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .npc_sel     (npc_sel),
        .br_taken    (br_taken),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .stall       (stall),
        .imem        (bus.master),
        .instr       (instr),
        .instr_valid (instr_valid),
        .misalign    (misalign)
    );

    // External incrementer.
    assign pc_plus4 = pc_out + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acknowledge the current request and record the expected result.
    task automatic do_fetch();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        sb_pc.push_back(bus.imem_addr);
        sb_ins.push_back(bus.imem_rdata);
        last_instr = bus.imem_rdata;
        tick();
        bus.imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (pc_out !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_out, RESET_PC); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b expected 1", bus.imem_req); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        npc_sel = 2'b00;
        stall   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.imem_addr !== RESET_PC + 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr%0d: got %h expected %h", i, bus.imem_addr, RESET_PC + 32'(4 * i)); end
            n_checks++; if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_fetch%0d: valid=%b req=%b expected 0/1", i, instr_valid, bus.imem_req); end
            do_fetch();
            n_checks++; if (instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_hold%0d: valid=%b req=%b expected 1/0", i, instr_valid, bus.imem_req); end
            e_pc = sb_pc.pop_front(); e_ins = sb_ins.pop_front();
            n_checks++; if (instr !== e_ins || pc_out !== e_pc) begin n_fail++; $display("FAIL seq_sb%0d: instr=%h pc=%h expected %h/%h", i, instr, pc_out, e_ins, e_pc); end
            tick();
        end
        n_checks++; if (bus.imem_addr !== 32'h0040_000C) begin n_fail++; $display("FAIL seq_end: got %h expected 0040000c", bus.imem_addr); end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 2; t++) begin
            eret = 1'b1; epc = 32'h0040_0010;
            tick();
            eret = 1'b0;
            n_checks++; if (bus.imem_addr !== 32'h0040_0010 || misalign !== 1'b0) begin n_fail++; $display("FAIL br_eret%0d: addr=%h mis=%b expected 00400010/0", t, bus.imem_addr, misalign); end
            npc_sel = 2'b01; br_taken = (t == 0); imm16 = 16'hFFFC;
            do_fetch();
            e_pc = sb_pc.pop_front(); e_ins = sb_ins.pop_front();
            n_checks++; if (instr !== e_ins || pc_out !== e_pc) begin n_fail++; $display("FAIL br_sb%0d: instr=%h pc=%h expected %h/%h", t, instr, pc_out, e_ins, e_pc); end
            tick();
            e_pc = (t == 0) ? 32'h0040_0004 : 32'h0040_0014;
            n_checks++; if (bus.imem_addr !== e_pc || instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_target%0d: addr=%h valid=%b expected %h/0", t, bus.imem_addr, instr_valid, e_pc); end
        end
    endtask

    task automatic test_jump();
        eret = 1'b1; epc = 32'h0040_0020;
        tick();
        eret = 1'b0;
        npc_sel = 2'b10; instr_index = 26'h010_0008;
        do_fetch();
        e_pc = sb_pc.pop_front(); e_ins = sb_ins.pop_front();
        n_checks++; if (instr !== e_ins || pc_out !== e_pc) begin n_fail++; $display("FAIL j_sb: instr=%h pc=%h expected %h/%h", instr, pc_out, e_ins, e_pc); end
        tick();
        n_checks++; if (pc_out !== 32'h0040_0020 || misalign !== 1'b0) begin n_fail++; $display("FAIL j_target: pc=%h mis=%b expected 00400020/0", pc_out, misalign); end
        npc_sel = 2'b11; rs_val = 32'h0040_0103;
        do_fetch();
        e_pc = sb_pc.pop_front(); e_ins = sb_ins.pop_front();
        n_checks++; if (instr !== e_ins || pc_out !== e_pc) begin n_fail++; $display("FAIL jr_sb: instr=%h pc=%h expected %h/%h", instr, pc_out, e_ins, e_pc); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL jr_early_mis: got %b expected 0", misalign); end
        tick();
        n_checks++; if (pc_out !== 32'h0040_0100 || misalign !== 1'b1) begin n_fail++; $display("FAIL jr_target: pc=%h mis=%b expected 00400100/1", pc_out, misalign); end
        tick();
        n_checks++; if (misalign !== 1'b0 || pc_out !== 32'h0040_0100) begin n_fail++; $display("FAIL jr_pulse: mis=%b pc=%h expected 0/00400100", misalign, pc_out); end
        npc_sel = 2'b00;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        do_fetch();
        e_pc = sb_pc.pop_front(); e_ins = sb_ins.pop_front();
        n_checks++; if (instr !== e_ins || pc_out !== e_pc) begin n_fail++; $display("FAIL st_sb: instr=%h pc=%h expected %h/%h", instr, pc_out, e_ins, e_pc); end
        for (int i = 0; i < 5; i++) begin
            bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;
            tick();
            n_checks++;
            if (pc_out !== 32'h0040_0100 || instr !== last_instr || instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL st_hold%0d: pc=%h instr=%h valid=%b req=%b expected 00400100/%h/1/0", i, pc_out, instr, instr_valid, bus.imem_req, last_instr);
            end
        end
        bus.imem_ack = 1'b0;
        stall = 1'b0;
        tick();
        n_checks++; if (pc_out !== 32'h0040_0104 || instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL st_release: pc=%h valid=%b req=%b expected 00400104/0/1", pc_out, instr_valid, bus.imem_req); end
        tick();
        n_checks++; if (pc_out !== 32'h0040_0104) begin n_fail++; $display("FAIL st_once: pc=%h expected 00400104", pc_out); end
    endtask

    task automatic test_exception();
        exc_req = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        exc_req = 1'b0; bus.imem_ack = 1'b0;
        n_checks++; if (pc_out !== EXC_VECTOR || instr !== last_instr || instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL exc_ack: pc=%h instr=%h valid=%b req=%b expected %h/%h/0/1", pc_out, instr, instr_valid, bus.imem_req, EXC_VECTOR, last_instr); end
        stall = 1'b1;
        do_fetch();
        e_pc = sb_pc.pop_front(); e_ins = sb_ins.pop_front();
        n_checks++; if (instr !== e_ins || pc_out !== e_pc) begin n_fail++; $display("FAIL exc_sb: instr=%h pc=%h expected %h/%h", instr, pc_out, e_ins, e_pc); end
        eret = 1'b1; epc = 32'h0040_0203;
        tick();
        eret = 1'b0;
        n_checks++; if (pc_out !== 32'h0040_0200 || misalign !== 1'b1 || instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL eret_hold: pc=%h mis=%b valid=%b req=%b expected 00400200/1/0/1", pc_out, misalign, instr_valid, bus.imem_req); end
        tick();
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL eret_pulse: mis=%b expected 0", misalign); end
        exc_req = 1'b1; eret = 1'b1; epc = 32'h0040_0303;
        tick();
        exc_req = 1'b0; eret = 1'b0;
        n_checks++; if (pc_out !== EXC_VECTOR || misalign !== 1'b0) begin n_fail++; $display("FAIL exc_prio: pc=%h mis=%b expected %h/0", pc_out, misalign, EXC_VECTOR); end
        stall = 1'b0;
    endtask

    task automatic test_reset_hold();
        stall = 1'b1;
        do_fetch();
        e_pc = sb_pc.pop_front(); e_ins = sb_ins.pop_front();
        n_checks++; if (instr !== e_ins || pc_out !== e_pc || instr_valid !== 1'b1) begin n_fail++; $display("FAIL rh_sb: instr=%h pc=%h valid=%b expected %h/%h/1", instr, pc_out, instr_valid, e_ins, e_pc); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (pc_out !== RESET_PC || instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || instr !== 32'h0) begin n_fail++; $display("FAIL rst_hold: pc=%h valid=%b req=%b instr=%h expected %h/0/1/0", pc_out, instr_valid, bus.imem_req, instr, RESET_PC); end
        stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1; npc_sel = 2'b00; br_taken = 1'b0; imm16 = 16'h0;
        instr_index = 26'h0; rs_val = 32'h0; exc_req = 1'b0; eret = 1'b0;
        epc = 32'h0; stall = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        last_instr = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_exception();
        test_reset_hold();
        n_checks++; if (sb_pc.size() != 0) begin n_fail++; $display("FAIL sb_empty: %0d entries left expected 0", sb_pc.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
